demux_1x8_sched: RTL and testbench
==================================

Name: demux_1x8_sched

Overview:
Sequencing controller for the 1x8 demux. Accepts a single valid/ready input stream and drives the 3-bit demux select and a one-hot per-output valid. Each word goes either to its addressed output or to the next enabled output in round-robin order, with per-output backpressure, a timeout and drop accounting. Sits between the upstream stream source and the eight demux consumers.

Parameters:
DATA_W, 8, width of data word
TIMEOUT, 16, cycles a word may wait in SEND before it is dropped; 0 disables the timeout
CNT_W, 8, width of the saturating drop counter

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
rr_mode  in  1  1 = round-robin over dest_en; 0 = addressed by in_dest
dest_en  in  8  per-output enable mask
in_valid  in  1  input word valid
in_ready  out  1  controller can accept a word
in_data  in  DATA_W  input word
in_dest  in  3  destination index, used only when rr_mode=0
sel  out  3  demux select {sel2,sel1,sel0}
out_valid  out  8  one-hot valid for the selected output
out_data  out  DATA_W  registered word presented to the demux
out_ready  in  8  per-output ready
busy  out  1  high while in SEND
err_drop  out  1  one-cycle pulse when a word is dropped
drop_cnt  out  CNT_W  saturating count of dropped words

Behaviour:
- Reset (async assert, sync deassert at top level): state=IDLE, sel=0, out_valid=0, out_data=0, busy=0, err_drop=0, drop_cnt=0, rr_ptr=7, timer=0. in_ready=0 during reset.
- Handshakes: an input transfer occurs when in_valid & in_ready. An output transfer occurs when out_valid[sel] & out_ready[sel]. out_valid is 0 or one-hot, and is always equal to (busy << sel).
- rr_mode and dest_en are sampled only at capture.
- FSM states are IDLE and SEND.
- IDLE:
  - in_ready=1, except when rr_mode=1 and dest_en==0, where in_ready=0.
  - On transfer in addressed mode with dest_en[in_dest]=1: register in_data and sel=in_dest, go to SEND, timer=0.
  - On transfer in addressed mode with dest_en[in_dest]=0: word is accepted and dropped. err_drop pulses next cycle, drop_cnt increments. Stay in IDLE.
  - On transfer in rr mode: sel = first index i with dest_en[i]=1, searching cyclically from rr_ptr+1 (mod 8). rr_ptr updates to sel. Go to SEND.
- SEND:
  - out_valid[sel]=1 and busy=1. out_data and sel are held stable until the output transfer.
  - On output transfer: in_ready is combinationally 1 in the same cycle (in_ready = out_ready[sel], subject to the rr empty-mask rule). A simultaneous input transfer captures the next word with the IDLE rules and stays in SEND, or returns to IDLE if that word is dropped. Sustained throughput is therefore 1 word/cycle.
  - On output transfer with no new input: go to IDLE, out_valid=0 next cycle.
  - Timer increments each cycle without an output transfer. If TIMEOUT!=0 and timer reaches TIMEOUT-1 with no transfer, the word is dropped: err_drop pulses, drop_cnt increments, state goes to IDLE, and in_ready is 0 that cycle.
- drop_cnt saturates at 2^CNT_W-1. Simultaneous drop events in one cycle cannot occur; at most one per cycle.
- The rr pointer advances only on a successful capture; a timeout drop does not rewind it.
- dest_en changing while in SEND does not abort the held word.
- Reset mid-SEND clears all state immediately; the held word is lost and not counted as a drop.
- No combinational path from in_valid to outputs; the only combinational path is out_ready to in_ready.

Test Plan:
- Addressed routing: rr_mode=0, dest_en=8'hFF, send 8 words 0xA0..0xA7 with in_dest=0..7, all out_ready=1 -> each word appears on out_data with sel=i and out_valid=1<<i one cycle after capture, back-to-back with no bubbles, drop_cnt=0.
- Round-robin skip: rr_mode=1, dest_en=8'b1010_0101, 6 words -> sel sequence 0,2,5,7,0,2. rr_mode=1 with dest_en=0 -> in_ready stays 0.
- Backpressure: out_ready[3]=0 for 5 cycles while holding word 0x55 at sel=3 -> out_valid=8'h08, out_data=0x55 stable, in_ready=0. Raise ready -> transfer, then the next word is accepted in the same cycle.
- Timeout: TIMEOUT=16, out_ready=0 -> exactly 16 cycles after capture err_drop pulses once, drop_cnt=1, state returns to IDLE. Addressed word to disabled output 4 -> drop_cnt=2, no out_valid.
- Saturation: CNT_W=2, force 5 drops -> drop_cnt sticks at 3.
- Reset mid-SEND: assert rst_n=0 while out_valid=8'h20 -> out_valid, sel, busy and drop_cnt go to 0 asynchronously. After release, the first rr-mode word with dest_en=8'hFF goes to sel=0.

Source files
------------

// File: rtl/demux_1x8_sched_if.sv
// Stream-side bundle for the 1x8 demux controller: upstream valid/ready
// input plus the select/one-hot-valid/data bus toward the eight consumers.
interface demux_1x8_sched_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [2:0]        in_dest;
  logic [2:0]        sel;
  logic [7:0]        out_valid;
  logic [DATA_W-1:0] out_data;
  logic [7:0]        out_ready;

  // controller side
  modport master (
    input  in_valid, in_data, in_dest, out_ready,
    output in_ready, sel, out_valid, out_data
  );

  // environment side: stream source and demux consumers
  modport slave (
    output in_valid, in_data, in_dest, out_ready,
    input  in_ready, sel, out_valid, out_data
  );
endinterface

// File: rtl/demux_1x8_sched.sv
// Sequencing controller for a 1x8 demux. One word is held at a time; it is
// routed by address or round-robin over an enable mask, with a wait timeout
// and a saturating drop counter. A word leaving in the same cycle a new one
// arrives gives 1 word/cycle throughput.
module demux_1x8_sched #(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rr_mode_i,
  input  logic [7:0]         dest_en_i,
  demux_1x8_sched_if.master  bus,
  output logic               busy_o,
  output logic               err_drop_o,
  output logic [CNT_W-1:0]   drop_cnt_o
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = (TIMEOUT == 0) ? '0 : TMR_W'(TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [2:0]        sel_q, sel_d;
  logic [2:0]        rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic       busy;
  logic       rr_empty;
  logic       out_xfer;
  logic       timeout;
  logic       in_ready;
  logic       in_xfer;
  logic       drop;
  logic [2:0] rr_pick;
  logic [7:0] ov;

  assign busy     = (state_q == SEND);
  assign rr_empty = rr_mode_i && (dest_en_i == 8'h00);
  assign out_xfer = busy && bus.out_ready[sel_q];
  assign timeout  = (TIMEOUT != 0) && busy && !out_xfer && (timer_q == TMR_LAST);
  // Only out_ready reaches in_ready combinationally; held low in reset.
  assign in_ready = rst_n && !rr_empty && (!busy || out_xfer);
  assign in_xfer  = bus.in_valid && in_ready;

  // First enabled output after the last round-robin grant, wrapping mod 8.
  always_comb begin
    logic       hit;
    logic [2:0] idx;
    rr_pick = rr_ptr_q;
    hit     = 1'b0;
    idx     = '0;
    for (int k = 1; k <= 8; k++) begin
      idx = rr_ptr_q + 3'(k);
      if (!hit && dest_en_i[idx]) begin
        rr_pick = idx;
        hit     = 1'b1;
      end
    end
  end

  // Next state: drain/timeout of the held word, then capture or drop of a new one.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    timer_d  = timer_q;
    drop     = 1'b0;

    if (busy) begin
      if (out_xfer) begin
        state_d = IDLE;
      end else if (timeout) begin
        state_d = IDLE;
        drop    = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end

    if (in_xfer) begin
      if (rr_mode_i) begin
        sel_d    = rr_pick;
        rr_ptr_d = rr_pick;
        data_d   = bus.in_data;
        timer_d  = '0;
        state_d  = SEND;
      end else if (dest_en_i[bus.in_dest]) begin
        sel_d   = bus.in_dest;
        data_d  = bus.in_data;
        timer_d = '0;
        state_d = SEND;
      end else begin
        drop    = 1'b1;
        state_d = IDLE;
      end
    end

    err_d = drop;
    cnt_d = (drop && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;
  end

  // State and datapath registers; a reset mid-send simply loses the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      rr_ptr_q <= 3'd7;
      data_q   <= '0;
      timer_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // One-hot valid per output lane: equals busy << sel.
  for (genvar g = 0; g < 8; g++) begin : g_ov
    assign ov[g] = busy && (sel_q == 3'(g));
  end

  assign bus.in_ready  = in_ready;
  assign bus.sel       = sel_q;
  assign bus.out_valid = ov;
  assign bus.out_data  = data_q;
  assign busy_o        = busy;
  assign err_drop_o    = err_q;
  assign drop_cnt_o    = cnt_q;

endmodule

// File: tb/tb_demux_1x8_sched.sv
// Directed bench for demux_1x8_sched. Inputs change and outputs are sampled
// on the falling edge; the DUT registers on the rising edge.
module tb_demux_1x8_sched;

  logic       clk;
  logic       rst_n;
  logic       rr_mode;
  logic [7:0] dest_en;
  logic       busy;
  logic       err_drop;
  logic [1:0] drop_cnt;

  int tests = 0;
  int fails = 0;

  demux_1x8_sched_if #(.DATA_W(8)) bus ();

  demux_1x8_sched #(.DATA_W(8), .TIMEOUT(16), .CNT_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rr_mode_i  (rr_mode),
    .dest_en_i  (dest_en),
    .bus        (bus.master),
    .busy_o     (busy),
    .err_drop_o (err_drop),
    .drop_cnt_o (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; rr_mode = 1'b0; dest_en = 8'hFF;
    bus.in_valid = 1'b1; bus.in_data = 8'h00; bus.in_dest = 3'd0; bus.out_ready = 8'hFF;
    #3;
    tests++;
    if ({bus.sel, bus.out_valid, bus.out_data, busy, err_drop, drop_cnt, bus.in_ready} !== 24'h0) begin
      fails++;
      $display("FAIL reset_outs: sel=%0d ov=%h od=%h busy=%b err=%b cnt=%0d rdy=%b want all 0",
               bus.sel, bus.out_valid, bus.out_data, busy, err_drop, drop_cnt, bus.in_ready);
    end
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; bus.in_valid = 1'b0;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_addressed();
    rr_mode = 1'b0; dest_en = 8'hFF; bus.out_ready = 8'hFF;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        tests++;
        if ({bus.sel, bus.out_valid, bus.out_data} !== {3'(i-1), 8'(1 << (i-1)), 8'(8'hA0 + i - 1)}) begin
          fails++;
          $display("FAIL addr_word%0d: sel=%0d ov=%h od=%h want sel=%0d ov=%h od=%h",
                   i-1, bus.sel, bus.out_valid, bus.out_data, i-1, 8'(1 << (i-1)), 8'(8'hA0 + i - 1));
        end
      end
      if (i < 8) begin
        bus.in_valid = 1'b1; bus.in_data = 8'(8'hA0 + i); bus.in_dest = 3'(i);
        #1;
        tests++;
        if (bus.in_ready !== 1'b1) begin
          fails++; $display("FAIL addr_ready%0d: got %b want 1", i, bus.in_ready);
        end
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    @(negedge clk);
    tests++;
    if ({bus.out_valid, busy, drop_cnt} !== 11'h0) begin
      fails++; $display("FAIL addr_drain: ov=%h busy=%b cnt=%0d want 0/0/0", bus.out_valid, busy, drop_cnt);
    end
  endtask

  task automatic test_rr_skip();
    logic [2:0] exp_sel [6];
    exp_sel = '{3'd0, 3'd2, 3'd5, 3'd7, 3'd0, 3'd2};
    rr_mode = 1'b1; dest_en = 8'b1010_0101; bus.out_ready = 8'hFF;
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        tests++;
        if ({bus.sel, bus.out_valid, bus.out_data} !== {exp_sel[i-1], 8'(1 << exp_sel[i-1]), 8'(8'hB0 + i - 1)}) begin
          fails++;
          $display("FAIL rr_word%0d: sel=%0d ov=%h od=%h want sel=%0d",
                   i-1, bus.sel, bus.out_valid, bus.out_data, exp_sel[i-1]);
        end
      end
      if (i < 6) begin
        bus.in_valid = 1'b1; bus.in_data = 8'(8'hB0 + i);
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    @(negedge clk);
    dest_en = 8'h00; bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++;
      if ({bus.in_ready, bus.out_valid} !== 9'h0) begin
        fails++; $display("FAIL rr_empty_mask%0d: rdy=%b ov=%h want 0/00", k, bus.in_ready, bus.out_valid);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    rr_mode = 1'b0; dest_en = 8'hFF; bus.out_ready = 8'hF7;
    bus.in_valid = 1'b1; bus.in_data = 8'h55; bus.in_dest = 3'd3;
    @(negedge clk);
    bus.in_data = 8'h66; bus.in_dest = 3'd1;
    for (int k = 0; k < 5; k++) begin
      #1;
      tests++;
      if ({bus.out_valid, bus.out_data, bus.sel, bus.in_ready} !== {8'h08, 8'h55, 3'd3, 1'b0}) begin
        fails++;
        $display("FAIL bp_hold%0d: ov=%h od=%h sel=%0d rdy=%b want 08/55/3/0",
                 k, bus.out_valid, bus.out_data, bus.sel, bus.in_ready);
      end
      @(negedge clk);
    end
    bus.out_ready = 8'hFF;
    #1;
    tests++;
    if ({bus.in_ready, bus.out_valid} !== {1'b1, 8'h08}) begin
      fails++; $display("FAIL bp_release: rdy=%b ov=%h want 1/08", bus.in_ready, bus.out_valid);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    tests++;
    if ({bus.sel, bus.out_valid, bus.out_data} !== {3'd1, 8'h02, 8'h66}) begin
      fails++; $display("FAIL bp_next: sel=%0d ov=%h od=%h want 1/02/66", bus.sel, bus.out_valid, bus.out_data);
    end
    @(negedge clk);
    tests++;
    if (bus.out_valid !== 8'h00) begin
      fails++; $display("FAIL bp_drain: ov=%h want 00", bus.out_valid);
    end
  endtask

  task automatic test_timeout();
    rr_mode = 1'b0; dest_en = 8'hFF; bus.out_ready = 8'h00;
    bus.in_valid = 1'b1; bus.in_data = 8'h77; bus.in_dest = 3'd6;
    @(negedge clk);
    bus.in_valid = 1'b0;
    // 16 rising edges after capture the drop is registered.
    for (int k = 1; k <= 16; k++) begin
      #1;
      tests++;
      if ({err_drop, busy, bus.out_valid} !== {1'b0, 1'b1, 8'h40}) begin
        fails++; $display("FAIL to_wait%0d: err=%b busy=%b ov=%h want 0/1/40", k, err_drop, busy, bus.out_valid);
      end
      if (k == 16) begin
        bus.in_valid = 1'b1;
        #1;
        tests++;
        if (bus.in_ready !== 1'b0) begin
          fails++; $display("FAIL to_last_ready: got %b want 0", bus.in_ready);
        end
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    tests++;
    if ({err_drop, drop_cnt, busy, bus.out_valid} !== {1'b1, 2'd1, 1'b0, 8'h00}) begin
      fails++; $display("FAIL to_drop: err=%b cnt=%0d busy=%b ov=%h want 1/1/0/00", err_drop, drop_cnt, busy, bus.out_valid);
    end
    @(negedge clk);
    tests++;
    if (err_drop !== 1'b0) begin
      fails++; $display("FAIL to_pulse_width: err=%b want 0", err_drop);
    end
    dest_en = 8'hEF; bus.out_ready = 8'hFF;
    bus.in_valid = 1'b1; bus.in_data = 8'h88; bus.in_dest = 3'd4;
    @(negedge clk);
    bus.in_valid = 1'b0;
    tests++;
    if ({err_drop, drop_cnt, busy, bus.out_valid} !== {1'b1, 2'd2, 1'b0, 8'h00}) begin
      fails++; $display("FAIL disabled_drop: err=%b cnt=%0d busy=%b ov=%h want 1/2/0/00", err_drop, drop_cnt, busy, bus.out_valid);
    end
  endtask

  task automatic test_saturation();
    rr_mode = 1'b0; dest_en = 8'hEF; bus.in_dest = 3'd4; bus.in_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 5) bus.in_valid = 1'b0;
      tests++;
      if ({err_drop, drop_cnt} !== {1'b1, 2'd3}) begin
        fails++; $display("FAIL sat_drop%0d: err=%b cnt=%0d want 1/3", k, err_drop, drop_cnt);
      end
    end
  endtask

  task automatic test_reset_mid_send();
    rr_mode = 1'b0; dest_en = 8'hFF; bus.out_ready = 8'h00;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 8'h99; bus.in_dest = 3'd5;
    @(negedge clk);
    bus.in_valid = 1'b0;
    tests++;
    if (bus.out_valid !== 8'h20) begin
      fails++; $display("FAIL rst_pre: ov=%h want 20", bus.out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({bus.out_valid, bus.sel, busy, drop_cnt, err_drop, bus.in_ready} !== 16'h0) begin
      fails++;
      $display("FAIL rst_async: ov=%h sel=%0d busy=%b cnt=%0d err=%b rdy=%b want all 0",
               bus.out_valid, bus.sel, busy, drop_cnt, err_drop, bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rr_mode = 1'b1; dest_en = 8'hFF; bus.out_ready = 8'hFF;
    bus.in_valid = 1'b1; bus.in_data = 8'hAA;
    @(negedge clk);
    bus.in_valid = 1'b0;
    tests++;
    if ({bus.sel, bus.out_valid, bus.out_data, drop_cnt} !== {3'd0, 8'h01, 8'hAA, 2'd0}) begin
      fails++;
      $display("FAIL rst_rr_first: sel=%0d ov=%h od=%h cnt=%0d want 0/01/AA/0",
               bus.sel, bus.out_valid, bus.out_data, drop_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_addressed();
    test_rr_skip();
    test_backpressure();
    test_timeout();
    test_saturation();
    test_reset_mid_send();
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
